// File: rtl/serial_logic_unit.sv
// Bit-serial logic processor: two operand registers combined DIGIT bits per
// clock, LSB first, by a latched function and routing code.
module serial_logic_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       F,
  input  logic [1:0]       R,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W = $clog2(STEPS) + 1;
  localparam int unsigned MSB_SHIFT = WIDTH - DIGIT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [2:0]       r_f, w_f_nxt;
  logic [1:0]       r_r, w_r_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [DIGIT-1:0] w_a_lo, w_b_lo, w_fbits;
  logic [DIGIT-1:0] w_a_in, w_b_in;
  logic [WIDTH-1:0] w_a_shift, w_b_shift;
  logic             w_load;

  assign w_a_lo = r_a[DIGIT-1:0];
  assign w_b_lo = r_b[DIGIT-1:0];
  assign w_load = LoadA | LoadB;

  // Per-digit function of the low operand bits
  always_comb begin
    w_fbits = '0;
    case (r_f)
      3'b000:  w_fbits = w_a_lo & w_b_lo;
      3'b001:  w_fbits = w_a_lo | w_b_lo;
      3'b010:  w_fbits = w_a_lo ^ w_b_lo;
      3'b011:  w_fbits = '1;
      3'b100:  w_fbits = ~(w_a_lo & w_b_lo);
      3'b101:  w_fbits = ~(w_a_lo | w_b_lo);
      3'b110:  w_fbits = ~(w_a_lo ^ w_b_lo);
      default: w_fbits = '0;
    endcase
  end

  // Routing: choose what re-enters each register's MSB end
  always_comb begin
    w_a_in = w_a_lo;
    w_b_in = w_b_lo;
    case (r_r)
      2'b01:   w_b_in = w_fbits;
      2'b10:   w_a_in = w_fbits;
      2'b11: begin
        w_a_in = w_b_lo;
        w_b_in = w_a_lo;
      end
      default: ;
    endcase
  end

  assign w_a_shift = (r_a >> DIGIT) | (WIDTH'(w_a_in) << MSB_SHIFT);
  assign w_b_shift = (r_b >> DIGIT) | (WIDTH'(w_b_in) << MSB_SHIFT);

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_f_nxt     = r_f;
    w_r_nxt     = r_r;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (LoadA) w_a_nxt = Din;
        if (LoadB) w_b_nxt = Din;
        // A load in the same cycle defers the start
        if (!w_load && !Execute) begin
          w_state_nxt = SHIFT;
          w_f_nxt     = F;
          w_r_nxt     = R;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        w_a_nxt   = w_a_shift;
        w_b_nxt   = w_b_shift;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(STEPS - 1)) begin
          w_state_nxt = HALT;
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      HALT: begin
        if (LoadA) w_a_nxt = Din;
        if (LoadB) w_b_nxt = Din;
        // Wait for button release so a held press runs once
        if (Execute) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_f     <= w_f_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign Busy = r_busy;
  assign Done = r_done;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit at DIGIT=1 and DIGIT=4.
module tb_serial_logic_unit;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       la8, lb8, exe8;
  logic [7:0] din8;
  logic [2:0] f8;
  logic [1:0] r8;
  logic [7:0] a8, b8;
  logic       busy8, done8;

  logic       la4, lb4, exe4;
  logic [7:0] din4;
  logic [2:0] f4;
  logic [1:0] r4;
  logic [7:0] a4, b4;
  logic       busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_logic_unit #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .Clk(clk), .Reset(reset_n), .LoadA(la8), .LoadB(lb8), .Execute(exe8),
    .Din(din8), .F(f8), .R(r8), .Aval(a8), .Bval(b8), .Busy(busy8), .Done(done8)
  );

  serial_logic_unit #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .Clk(clk), .Reset(reset_n), .LoadA(la4), .LoadB(lb4), .Execute(exe4),
    .Din(din4), .F(f4), .R(r4), .Aval(a4), .Bval(b4), .Busy(busy4), .Done(done4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] a, input logic [7:0] b);
    din8 = a; la8 = 1'b1;
    tick();
    la8 = 1'b0; din8 = b; lb8 = 1'b1;
    tick();
    lb8 = 1'b0;
  endtask

  // Hold Execute low for 'press' cycles, observing for 'window' cycles
  task automatic run8(input logic [2:0] f, input logic [1:0] r, input int press,
                      input int window, output int busy_n, output int done_n,
                      output int done_at);
    busy_n = 0; done_n = 0; done_at = -1;
    f8 = f; r8 = r; exe8 = 1'b0;
    for (int i = 1; i <= window; i++) begin
      tick();
      if (i == press) exe8 = 1'b1;
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
    end
    exe8 = 1'b1;
  endtask

  task automatic wait_done8(output int found);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (done8) found = 1;
    end
  endtask

  initial begin
    int bn, dn, dat, found;
    reset_n = 1'b0;
    la8 = 0; lb8 = 0; exe8 = 1; din8 = '0; f8 = '0; r8 = '0;
    la4 = 0; lb4 = 0; exe4 = 1; din4 = '0; f4 = '0; r4 = '0;
    tick(); tick();
    check_eq("rst_a", 32'(a8), 32'h00);
    check_eq("rst_b", 32'(b8), 32'h00);
    check_eq("rst_busy", 32'(busy8), 32'h0);
    check_eq("rst_done", 32'(done8), 32'h0);
    check_eq("rst_a4", 32'(a4), 32'h00);
    reset_n = 1'b1;
    tick();

    // XOR into A
    load8(8'hB5, 8'h2C);
    check_eq("load_a", 32'(a8), 32'hB5);
    check_eq("load_b", 32'(b8), 32'h2C);
    run8(3'b010, 2'b10, 2, 14, bn, dn, dat);
    check_eq("xor_busy_cycles", 32'(bn), 32'd8);
    check_eq("xor_done_pulses", 32'(dn), 32'd1);
    check_eq("xor_latency", 32'(dat), 32'd9);
    check_eq("xor_a", 32'(a8), 32'h99);
    check_eq("xor_b", 32'(b8), 32'h2C);

    // XNOR into B, then swap
    run8(3'b110, 2'b01, 1, 14, bn, dn, dat);
    check_eq("xnor_a", 32'(a8), 32'h99);
    check_eq("xnor_b", 32'(b8), 32'h4A);
    run8(3'b110, 2'b11, 1, 14, bn, dn, dat);
    check_eq("swap_a", 32'(a8), 32'h4A);
    check_eq("swap_b", 32'(b8), 32'h99);

    // Held button runs exactly once; a new press runs again
    run8(3'b110, 2'b11, 40, 50, bn, dn, dat);
    check_eq("hold_busy_cycles", 32'(bn), 32'd8);
    check_eq("hold_done_pulses", 32'(dn), 32'd1);
    check_eq("hold_a", 32'(a8), 32'h99);
    check_eq("hold_b", 32'(b8), 32'h4A);
    run8(3'b110, 2'b11, 1, 14, bn, dn, dat);
    check_eq("repress_done_pulses", 32'(dn), 32'd1);
    check_eq("repress_a", 32'(a8), 32'h4A);
    check_eq("repress_b", 32'(b8), 32'h99);

    // Load and F change during SHIFT are ignored
    load8(8'hB5, 8'h2C);
    f8 = 3'b010; r8 = 2'b10; exe8 = 1'b0;
    tick();
    exe8 = 1'b1;
    tick(); tick();
    din8 = 8'hFF; la8 = 1'b1; f8 = 3'b000;
    tick();
    la8 = 1'b0;
    check_eq("midload_busy", 32'(busy8), 32'h1);
    wait_done8(found);
    check_eq("midload_done_seen", 32'(found), 32'd1);
    check_eq("midload_a", 32'(a8), 32'h99);
    check_eq("midload_b", 32'(b8), 32'h2C);

    // Load in IDLE with Execute low defers the start by one cycle
    tick();
    din8 = 8'h0F; la8 = 1'b1; exe8 = 1'b0; f8 = 3'b111; r8 = 2'b10;
    tick();
    la8 = 1'b0;
    check_eq("defer_a_loaded", 32'(a8), 32'h0F);
    check_eq("defer_busy_low", 32'(busy8), 32'h0);
    tick();
    exe8 = 1'b1;
    check_eq("defer_busy_high", 32'(busy8), 32'h1);
    wait_done8(found);
    check_eq("defer_done_seen", 32'(found), 32'd1);
    check_eq("defer_a", 32'(a8), 32'h00);
    check_eq("defer_b", 32'(b8), 32'h2C);

    // Reset in the 4th SHIFT cycle aborts the operation
    tick();
    load8(8'hB5, 8'h2C);
    f8 = 3'b010; r8 = 2'b10; exe8 = 1'b0;
    tick();
    exe8 = 1'b1;
    tick(); tick(); tick();
    check_eq("abort_busy_before", 32'(busy8), 32'h1);
    reset_n = 1'b0;
    tick();
    check_eq("abort_a", 32'(a8), 32'h00);
    check_eq("abort_b", 32'(b8), 32'h00);
    check_eq("abort_busy", 32'(busy8), 32'h0);
    check_eq("abort_done", 32'(done8), 32'h0);
    reset_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) dn++;
    end
    check_eq("abort_no_done", 32'(dn), 32'd0);
    load8(8'hB5, 8'h2C);
    run8(3'b010, 2'b10, 1, 14, bn, dn, dat);
    check_eq("post_abort_done", 32'(dn), 32'd1);
    check_eq("post_abort_a", 32'(a8), 32'h99);
    check_eq("post_abort_b", 32'(b8), 32'h2C);

    // DIGIT=4: AND into A in two shift cycles
    din4 = 8'hB5; la4 = 1'b1;
    tick();
    la4 = 1'b0; din4 = 8'h2C; lb4 = 1'b1;
    tick();
    lb4 = 1'b0;
    f4 = 3'b000; r4 = 2'b10; exe4 = 1'b0;
    bn = 0; dn = 0; dat = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) exe4 = 1'b1;
      if (busy4) bn++;
      if (done4) begin
        dn++;
        if (dat < 0) dat = i;
      end
    end
    check_eq("d4_busy_cycles", 32'(bn), 32'd2);
    check_eq("d4_done_pulses", 32'(dn), 32'd1);
    check_eq("d4_latency", 32'(dat), 32'd3);
    check_eq("d4_a", 32'(a4), 32'h24);
    check_eq("d4_b", 32'(b4), 32'h2C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
